// File: rtl/motor_home_seq_if.sv
// Command/driver-side signal bundle for the homing sequencer.
// slave  : the sequencer (takes start/abort/sensors, drives the motor side)
// master : the command FSM / bench that drives requests and watches status
interface motor_home_seq_if;
  logic        home_start;
  logic        home_abort;
  logic [2:0]  sensor;
  logic        motor_en;
  logic        motor_dir;
  logic        step;
  logic        busy;
  logic        home_done;
  logic        home_fault;
  logic [15:0] step_cnt;

  modport slave (
    input  home_start, home_abort, sensor,
    output motor_en, motor_dir, step, busy, home_done, home_fault, step_cnt
  );

  modport master (
    output home_start, home_abort, sensor,
    input  motor_en, motor_dir, step, busy, home_done, home_fault, step_cnt
  );
endinterface

// File: rtl/motor_home_seq.sv
// Homing sequencer for one stepper axis: probes the end/centre sensors,
// steps toward centre, debounces the centre hit, settles, then reports done.
// Optional build macro HOME_DIR_MEMORY_EN: a no-sensor probe reuses the
// direction of the last step issued in the previous attempt (else left).
module motor_home_seq #(
  parameter int STEP_DIV      = 50000,
  parameter int DEB_CYCLES    = 1000,
  parameter int TIMEOUT_STEPS = 20000,
  parameter int SETTLE_CYCLES = 5000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  motor_home_seq_if.slave hs
);
  localparam int DIV_W = $clog2(STEP_DIV + 1);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      TMO      = 16'(TIMEOUT_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_SEEK, S_DEB, S_SETTLE, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sens_s1_q, sens_s2_q;
  logic             start_q;
  logic             dir_q, dir_d;
  logic             rev_q, rev_d;
  logic             step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             start_edge, l_hit, c_hit, r_hit, end_hit, probe_dir;

  assign l_hit      = sens_s2_q[0];
  assign c_hit      = sens_s2_q[1];
  assign r_hit      = sens_s2_q[2];
  // only the end sensor ahead of the carriage matters
  assign end_hit    = dir_q ? r_hit : l_hit;
  assign start_edge = hs.home_start & ~start_q;

`ifdef HOME_DIR_MEMORY_EN
  logic last_dir_q;
  assign probe_dir = last_dir_q;

  // remember the direction of every step actually issued; survives attempts
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                   last_dir_q <= 1'b0;
    else if (state_q == S_SEEK && step_d && !step_q)  last_dir_q <= dir_q;
  end
`else
  assign probe_dir = 1'b0;
`endif

  // sensor synchronizer, start edge detector and all sequencer state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sens_s1_q <= '0;
      sens_s2_q <= '0;
      start_q   <= 1'b0;
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      rev_q     <= 1'b0;
      step_q    <= 1'b0;
      div_q     <= '0;
      deb_q     <= '0;
      set_q     <= '0;
      cnt_q     <= '0;
    end else begin
      sens_s1_q <= hs.sensor;
      sens_s2_q <= sens_s1_q;
      start_q   <= hs.home_start;
      state_q   <= state_d;
      dir_q     <= dir_d;
      rev_q     <= rev_d;
      step_q    <= step_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      set_q     <= set_d;
      cnt_q     <= cnt_d;
    end
  end

  // next-state: step/divider/debounce/settle counters default to cleared
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rev_d   = rev_q;
    step_d  = 1'b0;
    div_d   = '0;
    deb_d   = '0;
    set_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: if (start_edge) state_d = S_PROBE;
      S_PROBE: begin
        cnt_d = '0;
        rev_d = 1'b0;
        if (c_hit)               state_d = S_SETTLE;
        else if (l_hit && r_hit) state_d = S_FAULT;
        else begin
          state_d = S_SEEK;
          if (l_hit)      dir_d = 1'b1;
          else if (r_hit) dir_d = 1'b0;
          else            dir_d = probe_dir;
        end
      end
      S_SEEK: begin
        step_d = step_q;
        div_d  = div_q;
        if (c_hit) begin
          state_d = S_DEB;
          step_d  = 1'b0;
          div_d   = '0;
          deb_d   = DEB_W'(1);  // the detecting cycle is the first high one
        end else if (cnt_q == TMO) begin
          state_d = S_FAULT;
          step_d  = 1'b0;
        end else if (end_hit) begin
          if (rev_q) begin
            state_d = S_FAULT;
            step_d  = 1'b0;
          end else begin
            dir_d = ~dir_q;
            rev_d = 1'b1;
            div_d = '0;
          end
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          step_d = ~step_q;
          if (!step_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DEB: begin
        if (!c_hit)                state_d = S_SEEK;
        else if (deb_q >= DEB_LAST) state_d = S_SETTLE;
        else                       deb_d = deb_q + DEB_W'(1);
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) state_d = S_DONE;
        else                   set_d = set_q + SET_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over everything, including a same-cycle start edge
    if (hs.home_abort) begin
      state_d = S_IDLE;
      step_d  = 1'b0;
      rev_d   = 1'b0;
      div_d   = '0;
      deb_d   = '0;
      set_d   = '0;
      cnt_d   = '0;
    end
  end

  assign hs.step       = step_q;
  assign hs.motor_dir  = dir_q;
  assign hs.step_cnt   = cnt_q;
  assign hs.motor_en   = (state_q == S_SEEK) || (state_q == S_DEB) || (state_q == S_SETTLE);
  assign hs.busy       = hs.motor_en || (state_q == S_PROBE);
  assign hs.home_done  = (state_q == S_DONE);
  assign hs.home_fault = (state_q == S_FAULT);
endmodule

// File: tb/tb_motor_home_seq.sv
// Directed bench for motor_home_seq with small timing parameters.
module tb_motor_home_seq;
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  int   vec_cnt   = 0;
  int   err_cnt   = 0;

  motor_home_seq_if hs ();

  motor_home_seq #(
    .STEP_DIV(4), .DEB_CYCLES(3), .TIMEOUT_STEPS(16), .SETTLE_CYCLES(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .hs       (hs)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] get_sig(input int sel);
    case (sel)
      0:       return hs.step_cnt;
      1:       return {15'd0, hs.home_done};
      2:       return {15'd0, hs.home_fault};
      3:       return {15'd0, hs.motor_dir};
      default: return {15'd0, hs.step};
    endcase
  endfunction

  // 0 step_cnt, 1 home_done, 2 home_fault, 3 motor_dir, 4 step
  task automatic wait_for(input string tag, input int sel, input logic [15:0] val, input int max);
    int n = 0;
    while (get_sig(sel) !== val && n < max) begin
      tick();
      n++;
    end
    chk(tag, {16'd0, get_sig(sel)}, {16'd0, val});
  endtask

  // leaves the bench one cycle after the edge, i.e. looking at PROBE
  task automatic start_pulse();
    hs.home_start = 1'b1;
    tick();
    hs.home_start = 1'b0;
  endtask

  task automatic set_sens(input logic [2:0] s);
    hs.sensor = s;
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rises;
    hs.home_start = 1'b0;
    hs.home_abort = 1'b0;
    hs.sensor     = 3'b000;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_flags", {hs.motor_en, hs.motor_dir, hs.step, hs.busy, hs.home_done, hs.home_fault}, 0);
    chk("rst_cnt", hs.step_cnt, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();

    // left end held: seek right, 8-cycle step period, centre after 5 steps
    set_sens(3'b001);
    start_pulse();
    chk("t1_probe_busy", hs.busy, 1);
    tick();
    chk("t1_seek_dir", hs.motor_dir, 1);
    chk("t1_seek_en", hs.motor_en, 1);
    chk("t1_seek_step0", hs.step, 0);
    wait_for("t1_step1", 0, 16'd1, 10);
    n = 0;
    while (hs.step_cnt != 16'd2 && n < 20) begin
      tick();
      n++;
    end
    chk("t1_period", n, 8);
    wait_for("t1_step5", 0, 16'd5, 40);
    hs.sensor = 3'b010;
    wait_for("t1_done", 1, 16'd1, 20);
    chk("t1_cnt", hs.step_cnt, 5);
    chk("t1_busy", hs.busy, 0);
    chk("t1_en", hs.motor_en, 0);

    // centre already high: PROBE -> SETTLE -> DONE six cycles after PROBE
    set_sens(3'b010);
    start_pulse();
    chk("t2_probe_busy", hs.busy, 1);
    chk("t2_probe_done", hs.home_done, 0);
    rises = 0;
    repeat (5) begin
      tick();
      if (hs.step) rises++;
    end
    chk("t2_settle_done", hs.home_done, 0);
    chk("t2_settle_en", hs.motor_en, 1);
    tick();
    chk("t2_done", hs.home_done, 1);
    chk("t2_cnt", hs.step_cnt, 0);
    chk("t2_nostep", rises, 0);

    // no sensors: go left, left end reverses to right, right end faults
    set_sens(3'b000);
    start_pulse();
    tick();
    chk("t3_dir0", hs.motor_dir, 0);
    wait_for("t3_step3", 0, 16'd3, 40);
    hs.sensor = 3'b001;
    wait_for("t3_dir1", 3, 16'd1, 10);
    hs.sensor = 3'b000;
    wait_for("t3_step7", 0, 16'd7, 60);
    hs.sensor = 3'b100;
    wait_for("t3_fault", 2, 16'd1, 10);
    chk("t3_cnt", hs.step_cnt, 7);
    chk("t3_en", hs.motor_en, 0);
    chk("t3_step", hs.step, 0);
    chk("t3_busy", hs.busy, 0);

    // no sensors ever: timeout at 16 steps; restart clears the fault
    set_sens(3'b000);
    start_pulse();
    chk("t4_probe_fault", hs.home_fault, 0);
    tick();
    chk("t4_cnt_clr", hs.step_cnt, 0);
    wait_for("t4_fault", 2, 16'd1, 200);
    chk("t4_cnt", hs.step_cnt, 16);
    chk("t4_step", hs.step, 0);
    start_pulse();
    chk("t4_refault", hs.home_fault, 0);
    chk("t4_rebusy", hs.busy, 1);
    hs.home_abort = 1'b1;
    tick();
    hs.home_abort = 1'b0;
    chk("t4_abort_busy", hs.busy, 0);

    // 2-cycle centre glitch bounces back to SEEK; 3-cycle hold settles
    tick();
    start_pulse();
    wait_for("t5_step2", 0, 16'd2, 30);
    hs.sensor = 3'b010;
    repeat (2) tick();
    hs.sensor = 3'b000;
    repeat (4) tick();
    chk("t5_cnt_kept", hs.step_cnt, 2);
    chk("t5_busy", hs.busy, 1);
    chk("t5_notdone", hs.home_done, 0);
    wait_for("t5_resume", 0, 16'd3, 20);
    hs.sensor = 3'b010;
    repeat (3) tick();
    hs.sensor = 3'b000;
    wait_for("t5_done", 1, 16'd1, 20);
    chk("t5_cnt", hs.step_cnt, 3);

    // abort with step high; abort beats a same-cycle start edge
    set_sens(3'b000);
    start_pulse();
    wait_for("t6_step_hi", 4, 16'd1, 20);
    hs.home_abort = 1'b1;
    tick();
    hs.home_abort = 1'b0;
    chk("t6_step", hs.step, 0);
    chk("t6_en", hs.motor_en, 0);
    chk("t6_busy", hs.busy, 0);
    chk("t6_cnt", hs.step_cnt, 0);
    hs.home_start = 1'b1;
    hs.home_abort = 1'b1;
    tick();
    chk("t6_abort_prio", hs.busy, 0);
    hs.home_abort = 1'b0;
    tick();
    chk("t6_no_edge", hs.busy, 0);
    hs.home_start = 1'b0;
    tick();

    // asynchronous reset mid-seek drops step immediately
    start_pulse();
    wait_for("t7_step_hi", 4, 16'd1, 20);
    sys_rst_n = 1'b0;
    #1;
    chk("t7_step", hs.step, 0);
    chk("t7_en", hs.motor_en, 0);
    chk("t7_cnt", hs.step_cnt, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
